// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-stage types, responder states and alignment rule.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_type_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } resp_state_t;

   typedef struct packed {
      logic        write;
      logic [1:0]  typ;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Type 2'b11 is reserved and behaves as a word access.
   function automatic logic mem_misaligned(input logic [1:0] typ, input logic [1:0] off);
      return (typ == MEM_HALF) ? off[0] : (typ[1] ? (off != 2'b00) : 1'b0);
   endfunction

endpackage

// File: rtl/mem_lane_extend.sv
// mem_lane_extend: load lane select with sign/zero extension, and store
// byte-enable plus lane replication.
module mem_lane_extend
   import mem_pkg::*;
(
   input  logic [1:0]  type_i,
   input  logic        sign_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_data_o,
   output logic [3:0]  st_be_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = word_i[{off_i, 3'b000} +: 8];
      half_v    = off_i[1] ? word_i[31:16] : word_i[15:0];
      ld_data_o = (type_i == MEM_BYTE) ? {{24{sign_i & byte_v[7]}}, byte_v} :
                  (type_i == MEM_HALF) ? {{16{sign_i & half_v[15]}}, half_v} : word_i;
      st_data_o = (type_i == MEM_BYTE) ? {4{wdata_i[7:0]}} :
                  (type_i == MEM_HALF) ? {2{wdata_i[15:0]}} : wdata_i;
      st_be_o   = (type_i == MEM_BYTE) ? (4'b0001 << off_i) :
                  (type_i == MEM_HALF) ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle load/store responder with valid/ready handshake,
// byte-lane steering, load extension, misalignment errors and stall.
module data_mem_resp
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_BITS  = 10,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [1:0]            req_type_i,
   input  logic                  req_sign_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  stall_o
);

   localparam int         AW       = ADDR_BITS + 2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   resp_state_t           state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   mem_req_t              req_q, req_d, cur;
   logic [31:0]           rdata_q, rdata_d, ld_data, st_data, rd_word;
   logic                  err_q, err_d, commit, mis;
   logic [3:0]            st_be;
   logic [ADDR_BITS-1:0]  idx;
   logic [31:0]           mem [2**ADDR_BITS];
   logic                  unused_ok;

   // With LATENCY = 1 the commit happens on the accept edge, so the live request is used.
   assign cur       = (state_q == ST_IDLE) ? {req_write_i, req_type_i, req_sign_i, req_addr_i, req_wdata_i} : req_q;
   assign idx       = cur.addr[AW-1:2];
   assign mis       = mem_misaligned(cur.typ, cur.addr[1:0]);
   assign rd_word   = mem[idx];
   assign unused_ok = ^cur.addr[DATA_WIDTH-1:AW];

   mem_lane_extend u_lane (
      .type_i    (cur.typ),
      .sign_i    (cur.sign),
      .off_i     (cur.addr[1:0]),
      .word_i    (rd_word),
      .wdata_i   (cur.wdata),
      .ld_data_o (ld_data),
      .st_data_o (st_data),
      .st_be_o   (st_be)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: if (req_valid_i) begin
            req_d   = cur;
            cnt_d   = CNT_INIT;
            commit  = (LATENCY == 1);
            state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            commit  = (cnt_q == 4'd0);
            state_d = commit ? ST_RESP : ST_WAIT;
         end
         ST_RESP: state_d = rsp_ready_i ? ST_IDLE : ST_RESP;
         default: state_d = ST_IDLE;
      endcase
      rdata_d = commit ? ((cur.write || mis) ? 32'd0 : ld_data) : rdata_q;
      err_d   = commit ? mis : err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (commit && cur.write && !mis)
         for (int i = 0; i < 4; i++)
            if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign stall_o     = (state_q != ST_IDLE) || req_valid_i;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: randomized scoreboard bench against a byte-array memory model.
module tb_data_mem_resp;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_i = 1'b0, req_write_i = 1'b0, req_sign_i = 1'b0;
   logic [1:0]  req_type_i = 2'b00;
   logic [31:0] req_addr_i = '0, req_wdata_i = '0;
   logic        rsp_ready_i = 1'b0;
   logic        req_ready_o, rsp_valid_o, rsp_err_o, stall_o;
   logic [31:0] rsp_rdata_o;

   int unsigned checks = 0, failures = 0;
   logic [32:0] sb [$];
   logic [7:0]  mb [4096];

   data_mem_resp #(.DATA_WIDTH(32), .ADDR_BITS(10), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_write_i(req_write_i), .req_type_i(req_type_i), .req_sign_i(req_sign_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit misal(input logic [1:0] t, input logic [31:0] a);
      return (t == 2'd1 && a[0]) || (t[1] && a[1:0] != 2'd0);
   endfunction

   // Response checking: one pop per completed handshake.
   always @(negedge clk) begin
      if (rst_n && rsp_valid_o && rsp_ready_i) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e[32]});
            chk("rsp_rdata", rsp_rdata_o, e[31:0]);
         end
      end
   end

   task automatic model(input bit w, input logic [1:0] t, input bit s, input logic [31:0] a, input logic [31:0] d);
      int n;
      logic [31:0] v;
      n = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
      v = '0;
      if (misal(t, a)) begin
         sb.push_back({1'b1, 32'd0});
         return;
      end
      for (int k = 0; k < n; k++) begin
         if (w) mb[(a + k) % 4096] = d[8*k +: 8];
         else v |= 32'(mb[(a + k) % 4096]) << (8 * k);
      end
      if (!w && s && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
      sb.push_back({1'b0, w ? 32'd0 : v});
   endtask

   task automatic send(input bit w, input logic [1:0] t, input bit s, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input bit bp);
      int n;
      logic [31:0] rd0;
      logic        er0;
      model(w, t, s, a, d);
      req_valid_i = 1'b1; req_write_i = w; req_type_i = t; req_sign_i = s;
      req_addr_i = a; req_wdata_i = d;
      n = 0;
      while (!req_ready_o && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      n = 0;
      while (!rsp_valid_o && n < 20) begin @(posedge clk); #1; n++; end
      chk("latency", n, LAT);
      rd0 = rsp_rdata_o; er0 = rsp_err_o;
      for (int h = 0; h < hold; h++) begin
         req_valid_i = bp;
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
         chk("bp_stall", {31'd0, stall_o}, 32'd1);
         chk("bp_rdata", rsp_rdata_o, rd0);
         chk("bp_err", {31'd0, rsp_err_o}, {31'd0, er0});
         if (bp) chk("bp_ready", {31'd0, req_ready_o}, 32'd0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      if (bp) chk("ready_after_hs", {31'd0, req_ready_o}, 32'd1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
      chk({tag, "_rsp_err"}, {31'd0, rsp_err_o}, 32'd0);
      chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) send(1, 2'd2, 0, i * 4, $urandom, 0, 0);
      send(1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 0, 0);
      send(0, 2'd2, 0, 32'h40, 0, 0, 0);
      send(1, 2'd2, 0, 32'h10, 32'h80F17F00, 0, 0);
      send(0, 2'd0, 1, 32'h13, 0, 0, 0);
      send(0, 2'd0, 0, 32'h13, 0, 0, 0);
      send(0, 2'd1, 1, 32'h12, 0, 0, 0);
      send(0, 2'd1, 0, 32'h10, 0, 0, 0);
      send(1, 2'd2, 0, 32'h20, 32'h11223344, 0, 0);
      send(1, 2'd0, 0, 32'h21, 32'h000000AA, 0, 0);
      send(1, 2'd1, 0, 32'h22, 32'h0000BBCC, 0, 0);
      send(0, 2'd2, 0, 32'h20, 0, 0, 0);
      send(0, 2'd2, 0, 32'h22, 0, 0, 0);
      send(1, 2'd1, 0, 32'h31, 32'h00005555, 0, 0);
      send(0, 2'd2, 0, 32'h30, 0, 0, 0);
      send(0, 2'd2, 0, 32'h40, 0, 5, 1);
      send(0, 2'd1, 1, 32'h12, 0, 0, 0);
      // Store to 0x50 interrupted by reset while waiting must not land.
      req_valid_i = 1'b1; req_write_i = 1'b1; req_type_i = 2'd2; req_sign_i = 1'b0;
      req_addr_i = 32'h50; req_wdata_i = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      chk("wait_stall", {31'd0, stall_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, 2'd2, 0, 32'h50, 0, 0, 0);
      send(1, 2'd2, 0, 32'h1000, 32'h13579BDF, 0, 0);
      send(0, 2'd2, 0, 32'h0000, 0, 0, 0);
      send(0, 2'd3, 0, 32'h0000, 0, 0, 0);
      for (int i = 0; i < 200; i++)
         send($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
              ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127)),
              $urandom, $urandom_range(0, 2), $urandom_range(0, 1));
      repeat (4) @(posedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Multi-cycle data-memory responder that services load/store requests from the pipeline memory stage over a valid/ready handshake. Performs byte-lane steering for byte, half and word stores, and sign- or zero-extension for loads. Flags misaligned accesses as errors. Asserts a stall to the hazard unit while a request is in flight.

## Interface
- `DATA_WIDTH`, 32: data and address width; only 32 is supported.
- `ADDR_BITS`, 10: word-index bits; storage is 2^ADDR_BITS 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to `rsp_valid_o`; legal range 1–15.
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, 1: request present.
- `req_ready_o`, out, 1: responder can accept a request.
- `req_write_i`, in, 1: 1 = store, 0 = load.
- `req_type_i`, in, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = reserved, treated as word.
- `req_sign_i`, in, 1: for loads, 1 = sign-extend, 0 = zero-extend; ignored for stores.
- `req_addr_i`, in, DATA_WIDTH: byte address.
- `req_wdata_i`, in, DATA_WIDTH: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid_o`, out, 1: response present.
- `rsp_ready_i`, in, 1: consumer accepts the response.
- `rsp_rdata_o`, out, DATA_WIDTH: extended load data; 0 for stores and errors.
- `rsp_err_o`, out, 1: misaligned access.
- `stall_o`, out, 1: request in flight or response pending.

## Operation
- FSM states:
  - IDLE: `req_ready_o` = 1. On `req_valid_i`, latch write, type, sign, address and data, load the counter with `LATENCY`-1, and go to WAIT. If `LATENCY` = 1, go directly to RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: `rsp_valid_o` = 1. On `rsp_ready_i`, return to IDLE. The block does not accept back-to-back requests in the same cycle.
- Alignment check, evaluated on latched values:
  - Half access is misaligned when addr[0] = 1.
  - Word access is misaligned when addr[1:0] ≠ 0.
  - Misaligned access: no write, `rsp_err_o` = 1, `rsp_rdata_o` = 0.
- Word index is addr[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses alias (wrap) modulo 4·2^ADDR_BITS.
- Store:
  - Byte enables are derived from type and addr[1:0]. Data is replicated across lanes (byte ×4, half ×2).
  - The write commits exactly once, on the WAIT→RESP (or IDLE→RESP) transition edge.
- Load:
  - The word is read on the same transition edge and registered.
  - Lane select uses addr[1:0]; extension follows `req_sign_i`.
  - Result is held stable in RESP.
- Storage contents are not reset. Only the FSM, counter and outputs are reset.
- `stall_o` = 1 in WAIT and RESP; additionally, `stall_o` = `req_valid_i` in IDLE.

## Timing
- Reset values: state IDLE, `req_ready_o` = 1, `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0, `stall_o` = 0.
- Request accepted at edge T → `rsp_valid_o` = 1 from edge T+`LATENCY`, held until `rsp_ready_i` is sampled high.
- `rsp_*` outputs are registered and stable while `rsp_valid_o` = 1 and `rsp_ready_i` = 0.
- `req_ready_o` is a combinational function of the state only; there is no path from `req_valid_i`.
- Reset asserted mid-operation: returns to IDLE immediately. An uncommitted store is dropped; a committed store remains in the array.
- `req_valid_i` held during WAIT/RESP is ignored and is not latched again until IDLE.

## Structure
- Shared package `mem_pkg`:
  - `mem_type_t` enum: MEM_BYTE, MEM_HALF, MEM_WORD.
  - State enum `resp_state_t`.
  - Function `mem_misaligned(type, addr[1:0])`.
- The same package is used by the memory-stage initiator.
- One sub-module, `mem_lane_extend`: combinational lane select plus sign/zero extension, and the store byte-enable/replication generator. It is reusable by the writeback path.
- The storage array is inferred inside `data_mem_resp`.

## Test plan
- **Word round trip:** `LATENCY` = 2; store 0xDEADBEEF at 0x40, then load word at 0x40 → `rsp_valid_o` 2 cycles after acceptance, rdata 0xDEADBEEF, err 0.
- **Byte/half extension:** store 0x80F17F00 at 0x10.
  - LB at 0x13 with sign = 1 → 0xFFFFFF80.
  - LBU at 0x13 → 0x00000080.
  - LH at 0x12 with sign = 1 → 0xFFFF80F1.
  - LHU at 0x10 → 0x00007F00.
- **Partial store:** word 0x11223344 at 0x20; SB 0xAA at 0x21, then SH 0xBBCC at 0x22 → word load returns 0xBBCCAA44.
- **Misaligned:**
  - LW at 0x22 → err 1, rdata 0.
  - SH at 0x31 → err 1, and a subsequent word load at 0x30 is unchanged.
- **Back-pressure:** hold `rsp_ready_i` = 0 for 5 cycles → `rsp_valid_o`/data stable and `stall_o` = 1 throughout; a new `req_valid_i` is not accepted until 1 cycle after the handshake.
- **Reset and aliasing:**
  - Assert `rst_n` = 0 during WAIT of a store to 0x50 → outputs return to reset values, and a later load at 0x50 returns the old data.
  - With `ADDR_BITS` = 10, a store at 0x1000 is read back at 0x0000.
